reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
Parametrised general-purpose register file for the SCC core.
- Reads: three combinational ports (two operand ports, one branch-target port).
- Writes: one synchronous port, with the ALU/ID source select.
- Register 7 (ZERO_REG) is hardwired to zero.
- Optional write-to-read bypass.
- Per-register scoreboard of busy bits for hazard detection by the decoder.
- Non-user system bank: PC with load/increment, and CPSR with NZCV flags.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 3: user address width; the file holds 2**ADDR_W registers.
- ZERO_REG, 7: index that always reads 0 and ignores writes.
- BYPASS, 1: 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return stored values only.
- RESET_PC, 0: PC value after reset.
- PC_STEP, 4: PC increment per pc_inc.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- read_addr1  in  ADDR_W  operand port 1 address
- read_addr2  in  ADDR_W  operand port 2 address
- br_addr  in  ADDR_W  branch-target port address
- value1  out  DATA_W  data at read_addr1
- value2  out  DATA_W  data at read_addr2
- br_value  out  DATA_W  data at br_addr
- busy1  out  1  scoreboard bit for read_addr1
- busy2  out  1  scoreboard bit for read_addr2
- br_busy  out  1  scoreboard bit for br_addr
- write_addr  in  ADDR_W  write address
- write_value_alu  in  DATA_W  ALU write source
- write_value_id  in  DATA_W  ID write source
- write_data_sel  in  1  1 = ALU source, 0 = ID source
- write_enable  in  1  commit write
- sb_set  in  1  mark sb_addr busy (instruction issued)
- sb_addr  in  ADDR_W  register to mark busy
- pc_load  in  1  load PC from pc_in
- pc_inc  in  1  PC += PC_STEP
- pc_in  in  DATA_W  PC load value
- pc  out  DATA_W  current PC
- cpsr_we  in  1  update flags
- flags_in  in  4  {N,Z,C,V}
- cpsr  out  DATA_W  flags in [31:28], all other bits 0

Behaviour:
Reset (rst_n low, asynchronous, any cycle):
- All user registers = 0; all busy bits = 0.
- PC = RESET_PC; CPSR = 0.
- Outputs reflect reset values immediately. Reset during a write discards the write.

Reads:
- Combinational, zero latency; any address on any port.
- ZERO_REG always reads 0 and is never busy.

Write:
- On posedge clk with write_enable = 1, registers[write_addr] takes write_value_alu if write_data_sel = 1, else write_value_id.
- The same edge clears the busy bit of write_addr.
- A write to ZERO_REG is a no-op.

Bypass:
- When BYPASS = 1, write_enable = 1 and write_addr == read port address (not ZERO_REG), that port returns the selected write data in the same cycle.
- When BYPASS = 1, the matching busy output reads 0 in that cycle unless sb_set targets the same address that cycle.
- When BYPASS = 0, the read returns the old value until the next cycle.

Scoreboard:
- On posedge with sb_set = 1, busy[sb_addr] = 1; ignored for ZERO_REG.
- If sb_set and write_enable hit the same address in the same cycle, set wins: busy stays 1 and the data is still written.
- sb_set on an already-busy register has no extra effect. There is no counting; a single write clears the bit.

PC:
- Priority per edge: pc_load, then pc_inc, then hold.
- pc_inc adds PC_STEP modulo 2**DATA_W: wraps silently, no flag.
- pc_load with pc_inc in the same cycle: PC = pc_in.

CPSR:
- On posedge with cpsr_we = 1, bits [31:28] = flags_in. Bits [27:0] are always 0.
- CPSR is not addressable through the user ports.

Simultaneous events:
- All write-side inputs (user write, sb_set, PC, CPSR) are independent and may fire in the same cycle.

Test Plan:
1. Reset then read: rst_n low mid-cycle with registers previously loaded to 0xDEADBEEF → value1, value2, br_value = 0, pc = RESET_PC (0), cpsr = 0, all busy = 0 without waiting for a clock edge.
2. Source select and zero register:
   - write_addr = 3, sel = 1, alu = 0x1234, id = 0x5678, we = 1 → next cycle r3 reads 0x1234.
   - Then sel = 0 → r3 = 0x5678.
   - A write of 0xFFFFFFFF to r7 → r7 still reads 0.
3. Bypass:
   - BYPASS = 1, read_addr1 = 2, write r2 = 0xA5A5A5A5 → value1 = 0xA5A5A5A5 in the write cycle.
   - Rerun with BYPASS = 0 → old value in the write cycle, new value the next cycle.
4. Scoreboard:
   - sb_set r4 → busy on r4 ports = 1.
   - Write r4 → busy = 0 after the edge.
   - sb_set r4 and write r4 in the same cycle → busy stays 1 and data is updated.
   - sb_set r7 → busy stays 0.
5. PC:
   - pc_inc ×3 from 0 → 12.
   - pc_load 0xFFFFFFFC then pc_inc → 0x00000000 (wrap).
   - pc_load = 0x100 with pc_inc in the same cycle → 0x100.
6. CPSR: cpsr_we with flags_in = 4'b1010 → cpsr = 0xA0000000; cpsr_we low next cycle → value held.

Source files
------------

// File: rtl/reg_file_sb.sv
// General-purpose register file with hardwired zero register, optional
// write-to-read bypass, per-register busy scoreboard, and PC/CPSR system bank.
module reg_file_sb #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 3,
  parameter int unsigned       ZERO_REG = 7,
  parameter int unsigned       BYPASS   = 1,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [ADDR_W-1:0] br_addr,
  output logic [DATA_W-1:0] value1,
  output logic [DATA_W-1:0] value2,
  output logic [DATA_W-1:0] br_value,
  output logic              busy1,
  output logic              busy2,
  output logic              br_busy,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_value_alu,
  input  logic [DATA_W-1:0] write_value_id,
  input  logic              write_data_sel,
  input  logic              write_enable,
  input  logic              sb_set,
  input  logic [ADDR_W-1:0] sb_addr,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic [DATA_W-1:0] pc_in,
  output logic [DATA_W-1:0] pc,
  input  logic              cpsr_we,
  input  logic [3:0]        flags_in,
  output logic [DATA_W-1:0] cpsr
);

  localparam int unsigned       NREG     = 2 ** ADDR_W;
  localparam int unsigned       NPORT    = 3;
  localparam int unsigned       FLAGS_W  = 4;
  localparam logic [ADDR_W-1:0] ZADDR    = ADDR_W'(ZERO_REG);
  localparam logic [DATA_W-1:0] PC_INCR  = DATA_W'(PC_STEP);

  logic [DATA_W-1:0]  regs [NREG];
  logic [NREG-1:0]    busy;
  logic [DATA_W-1:0]  pc_r;
  logic [FLAGS_W-1:0] flags_r;

  logic [DATA_W-1:0]  wdata;
  logic               write_hit;
  logic               set_hit;
  logic [ADDR_W-1:0]  rd_addr [NPORT];
  logic [DATA_W-1:0]  rd_data [NPORT];
  logic               rd_busy [NPORT];

  assign wdata     = write_data_sel ? write_value_alu : write_value_id;
  assign write_hit = write_enable && (write_addr != ZADDR);
  assign set_hit   = sb_set && (sb_addr != ZADDR);

  assign rd_addr[0] = read_addr1;
  assign rd_addr[1] = read_addr2;
  assign rd_addr[2] = br_addr;

  // Combinational read ports; a bypassed write also hides the busy bit it is about to clear
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      logic fwd;
      logic same_set;
      fwd        = (BYPASS != 0) && write_hit && (rd_addr[p] == write_addr);
      same_set   = sb_set && (sb_addr == rd_addr[p]);
      rd_data[p] = regs[rd_addr[p]];
      rd_busy[p] = busy[rd_addr[p]];
      if (rd_addr[p] == ZADDR) begin
        rd_data[p] = '0;
        rd_busy[p] = 1'b0;
      end else if (fwd) begin
        rd_data[p] = wdata;
        if (!same_set) rd_busy[p] = 1'b0;
      end
    end
  end

  assign value1   = rd_data[0];
  assign value2   = rd_data[1];
  assign br_value = rd_data[2];
  assign busy1    = rd_busy[0];
  assign busy2    = rd_busy[1];
  assign br_busy  = rd_busy[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (write_hit) begin
      regs[write_addr] <= wdata;
    end
  end

  // Set is applied after clear so an issue in the commit cycle keeps the register busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      if (write_hit) busy[write_addr] <= 1'b0;
      if (set_hit)   busy[sb_addr]    <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r <= RESET_PC;
    end else if (pc_load) begin
      pc_r <= pc_in;
    end else if (pc_inc) begin
      pc_r <= pc_r + PC_INCR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_r <= '0;
    end else if (cpsr_we) begin
      flags_r <= flags_in;
    end
  end

  assign pc   = pc_r;
  assign cpsr = {flags_r, (DATA_W - FLAGS_W)'(0)};

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: a bypass and a non-bypass instance share
// stimulus; expected values are queued at drive time and popped at each check.
module tb_reg_file_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] read_addr1, read_addr2, br_addr;
  logic [AW-1:0] write_addr, sb_addr;
  logic [DW-1:0] write_value_alu, write_value_id, pc_in;
  logic          write_data_sel, write_enable, sb_set;
  logic          pc_load, pc_inc, cpsr_we;
  logic [3:0]    flags_in;

  logic [DW-1:0] b_v1, b_v2, b_br, b_pc, b_cpsr;
  logic          b_bz1, b_bz2, b_bzb;
  logic [DW-1:0] n_v1, n_v2, n_br, n_pc, n_cpsr;
  logic          n_bz1, n_bz2, n_bzb;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q [$];

  always #5 clk = ~clk;

  reg_file_sb #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .br_addr(br_addr),
    .value1(b_v1), .value2(b_v2), .br_value(b_br),
    .busy1(b_bz1), .busy2(b_bz2), .br_busy(b_bzb),
    .write_addr(write_addr), .write_value_alu(write_value_alu),
    .write_value_id(write_value_id), .write_data_sel(write_data_sel),
    .write_enable(write_enable), .sb_set(sb_set), .sb_addr(sb_addr),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_in(pc_in), .pc(b_pc),
    .cpsr_we(cpsr_we), .flags_in(flags_in), .cpsr(b_cpsr)
  );

  reg_file_sb #(.BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n),
    .read_addr1(read_addr1), .read_addr2(read_addr2), .br_addr(br_addr),
    .value1(n_v1), .value2(n_v2), .br_value(n_br),
    .busy1(n_bz1), .busy2(n_bz2), .br_busy(n_bzb),
    .write_addr(write_addr), .write_value_alu(write_value_alu),
    .write_value_id(write_value_id), .write_data_sel(write_data_sel),
    .write_enable(write_enable), .sb_set(sb_set), .sb_addr(sb_addr),
    .pc_load(pc_load), .pc_inc(pc_inc), .pc_in(pc_in), .pc(n_pc),
    .cpsr_we(cpsr_we), .flags_in(flags_in), .cpsr(n_cpsr)
  );

  task automatic expect_val(input logic [DW-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs);
    logic [DW-1:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 1'b0; sb_set = 1'b0; pc_load = 1'b0; pc_inc = 1'b0; cpsr_we = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] alu,
                    input logic [DW-1:0] id, input logic sel);
    write_addr = a; write_value_alu = alu; write_value_id = id;
    write_data_sel = sel; write_enable = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    read_addr1 = '0; read_addr2 = '0; br_addr = '0;
    write_addr = '0; sb_addr = '0; write_value_alu = '0; write_value_id = '0;
    pc_in = '0; write_data_sel = 1'b0; flags_in = '0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Load state that reset must wipe
    wr(3'd0, 32'hDEADBEEF, 32'h0, 1'b1);
    sb_set = 1'b1; sb_addr = 3'd5;
    tick();
    wr(3'd1, 32'h0, 32'hDEADBEEF, 1'b0);
    sb_set = 1'b0;
    tick();
    wr(3'd2, 32'hDEADBEEF, 32'h0, 1'b1);
    sb_set = 1'b1; sb_addr = 3'd2;
    pc_load = 1'b1; pc_in = 32'hDEADBEEF;
    cpsr_we = 1'b1; flags_in = 4'hF;
    tick();
    idle();
    read_addr1 = 3'd0; read_addr2 = 3'd1; br_addr = 3'd2;
    #1;
    expect_val(32'hDEADBEEF); chk("pre_br_value", b_br);
    expect_val(32'd1);        chk("pre_br_busy", DW'(b_bzb));
    expect_val(32'hDEADBEEF); chk("pre_pc", b_pc);

    // Asynchronous reset mid-cycle, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    expect_val(32'h0); chk("rst_value1", b_v1);
    expect_val(32'h0); chk("rst_value2", b_v2);
    expect_val(32'h0); chk("rst_br_value", b_br);
    expect_val(32'h0); chk("rst_busy", DW'({b_bz1, b_bz2, b_bzb}));
    expect_val(32'h0); chk("rst_pc", b_pc);
    expect_val(32'h0); chk("rst_cpsr", b_cpsr);
    expect_val(32'h0); chk("rst_nob_br_value", n_br);
    read_addr1 = 3'd5;
    #1;
    expect_val(32'h0); chk("rst_busy_r5", DW'(b_bz1));
    #1 rst_n = 1'b1;
    tick();

    // Source select and hardwired zero
    wr(3'd3, 32'h1234, 32'h5678, 1'b1);
    tick();
    idle(); read_addr1 = 3'd3;
    #1;
    expect_val(32'h1234); chk("sel_alu_r3", b_v1);
    expect_val(32'h1234); chk("sel_alu_r3_nob", n_v1);
    wr(3'd3, 32'h1234, 32'h5678, 1'b0);
    tick();
    idle();
    #1;
    expect_val(32'h5678); chk("sel_id_r3", b_v1);
    wr(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    read_addr1 = 3'd7;
    #1;
    expect_val(32'h0); chk("zero_no_bypass", b_v1);
    tick();
    idle();
    #1;
    expect_val(32'h0); chk("zero_after_write", b_v1);
    expect_val(32'h0); chk("zero_after_write_nob", n_v1);

    // Bypass versus stored-value read in the write cycle
    read_addr1 = 3'd2;
    wr(3'd2, 32'hA5A5A5A5, 32'h0, 1'b1);
    #1;
    expect_val(32'hA5A5A5A5); chk("byp_same_cycle", b_v1);
    expect_val(32'h0);        chk("nob_same_cycle", n_v1);
    tick();
    idle();
    #1;
    expect_val(32'hA5A5A5A5); chk("nob_next_cycle", n_v1);

    // Scoreboard
    read_addr2 = 3'd4; br_addr = 3'd4;
    sb_set = 1'b1; sb_addr = 3'd4;
    tick();
    idle();
    #1;
    expect_val(32'd1); chk("sb_set_busy2", DW'(b_bz2));
    expect_val(32'd1); chk("sb_set_br_busy", DW'(n_bzb));
    wr(3'd4, 32'h44, 32'h0, 1'b1);
    tick();
    idle();
    #1;
    expect_val(32'd0);  chk("sb_clear_busy2", DW'(b_bz2));
    expect_val(32'h44); chk("sb_clear_value2", n_v2);
    wr(3'd4, 32'h55, 32'h0, 1'b1);
    sb_set = 1'b1; sb_addr = 3'd4;
    tick();
    idle();
    #1;
    expect_val(32'd1);  chk("sb_set_wins_busy", DW'(b_bz2));
    expect_val(32'd1);  chk("sb_set_wins_busy_nob", DW'(n_bz2));
    expect_val(32'h55); chk("sb_set_wins_data", n_v2);
    wr(3'd4, 32'h66, 32'h0, 1'b1);
    #1;
    expect_val(32'd0); chk("byp_busy_hidden", DW'(b_bz2));
    expect_val(32'd1); chk("nob_busy_visible", DW'(n_bz2));
    tick();
    idle();
    read_addr1 = 3'd7;
    sb_set = 1'b1; sb_addr = 3'd7;
    tick();
    idle();
    #1;
    expect_val(32'd0); chk("sb_zero_reg", DW'(b_bz1));

    // PC increment, wrap, and load priority
    expect_val(32'h0); chk("pc_start", b_pc);
    pc_inc = 1'b1;
    tick(); tick(); tick();
    idle();
    #1;
    expect_val(32'd12); chk("pc_inc3", b_pc);
    pc_load = 1'b1; pc_in = 32'hFFFFFFFC;
    tick();
    idle(); pc_inc = 1'b1;
    tick();
    idle();
    #1;
    expect_val(32'h0); chk("pc_wrap", b_pc);
    pc_load = 1'b1; pc_inc = 1'b1; pc_in = 32'h100;
    tick();
    idle();
    #1;
    expect_val(32'h100); chk("pc_load_priority", n_pc);

    // CPSR update and hold
    cpsr_we = 1'b1; flags_in = 4'b1010;
    tick();
    idle(); flags_in = 4'b0101;
    #1;
    expect_val(32'hA0000000); chk("cpsr_write", b_cpsr);
    tick();
    #1;
    expect_val(32'hA0000000); chk("cpsr_hold", b_cpsr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
